divider_nopipe: RTL

- Sequential, non-pipelined radix-2 restoring divider. It is the inverse-operation companion to the team's shift-add multiplier.
- Accepts dividend/divisor through a valid/ready handshake. Iterates one quotient bit per cycle, then presents quotient and remainder with a one-cycle done pulse.
- Used in datapaths that need occasional division without the area of an array divider.

---
 rtl/divider_nopipe.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/divider_nopipe.sv
// ---------------------------------------------------------------------------
// divider_nopipe
//   Sequential radix-2 restoring divider, one quotient bit per clock.
//   Operands are taken through a valid/ready handshake. After DW iterations,
//   quotient and remainder are registered and flagged by a one-cycle res_done
//   pulse. The results hold until the next res_done.
//
//   Optional build macro: DIVIDER_SIGNED_EN
//     When defined, operands and results are two's complement. The core
//     divides magnitudes and the signs are fixed up in the DONE-entry
//     register. Division truncates toward zero.
//     When undefined, the divider is unsigned only and no sign logic is built.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   in_vld       operands valid
//   in_rdy       block can accept operands this cycle
//   dividend     dividend [DW-1:0]
//   divisor      divisor  [DW-1:0]
//   res_done     one-cycle pulse, result valid this cycle
//   quotient     quotient [DW-1:0], held until next res_done
//   remainder    remainder [DW-1:0], held until next res_done
//   div_by_zero  divisor was zero for the presented result
//   busy         high while iterating
// ---------------------------------------------------------------------------
module divider_nopipe #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          res_done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero,
  output logic          busy
);

  localparam int CNTW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [CNTW-1:0] r_cnt;
  logic [DW-1:0]   r_dq;     // dividend shifting out / quotient shifting in
  logic [DW-1:0]   r_p;      // partial remainder
  logic [DW-1:0]   r_div;    // divisor magnitude
  logic [DW-1:0]   r_dvd;    // original dividend, returned on divide-by-zero
  logic            r_zero;
  logic [DW-1:0]   r_quo;
  logic [DW-1:0]   r_rem;
  logic            r_dbz;

  logic            w_accept;
  logic            w_last;
  logic [DW-1:0]   w_a_mag;
  logic [DW-1:0]   w_b_mag;
  logic [DW:0]     w_p_sh;
  logic            w_ge;
  logic [DW-1:0]   w_p_nx;
  logic [DW-1:0]   w_dq_nx;
  logic [DW-1:0]   w_q_fin;
  logic [DW-1:0]   w_r_fin;

`ifdef DIVIDER_SIGNED_EN
  logic            r_q_neg;
  logic            r_r_neg;
  logic            w_a_neg;
  logic            w_b_neg;

  assign w_a_neg = dividend[DW-1];
  assign w_b_neg = divisor[DW-1];
  // -2^(DW-1) maps to itself, which as an unsigned magnitude is still correct.
  assign w_a_mag = w_a_neg ? ('0 - dividend) : dividend;
  assign w_b_mag = w_b_neg ? ('0 - divisor)  : divisor;
`else
  assign w_a_mag = dividend;
  assign w_b_mag = divisor;
`endif

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  assign w_last = (r_cnt == CNTW'(DW - 1));

  always_comb begin
    w_state_nx = r_state;
    in_rdy     = 1'b1;
    busy       = 1'b0;
    res_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_vld) w_state_nx = S_CALC;
      end
      S_CALC: begin
        in_rdy = 1'b0;
        busy   = 1'b1;
        if (w_last) w_state_nx = S_DONE;
      end
      S_DONE: begin
        res_done   = 1'b1;
        w_state_nx = in_vld ? S_CALC : S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_accept = in_vld && in_rdy;

  // ---------------------------------------------------------------------
  // One restoring iteration
  // ---------------------------------------------------------------------
  assign w_p_sh  = {r_p, r_dq[DW-1]};
  assign w_ge    = (w_p_sh >= {1'b0, r_div});
  // After a subtraction, P < divisor, so the top bit is always zero and P fits
  // in DW bits. The carry bit is only needed for the compare.
  assign w_p_nx  = w_ge ? DW'(w_p_sh - {1'b0, r_div}) : w_p_sh[DW-1:0];
  assign w_dq_nx = {r_dq[DW-2:0], w_ge};

  // Final result formed from the last iteration, written on DONE entry.
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    w_q_fin = r_q_neg ? ('0 - w_dq_nx) : w_dq_nx;
    w_r_fin = r_r_neg ? ('0 - w_p_nx)  : w_p_nx;
`else
    w_q_fin = w_dq_nx;
    w_r_fin = w_p_nx;
`endif
    if (r_zero) begin
      w_q_fin = '1;
      w_r_fin = r_dvd;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dq    <= '0;
      r_p     <= '0;
      r_div   <= '0;
      r_dvd   <= '0;
      r_zero  <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_dq    <= w_a_mag;
      r_p     <= '0;
      r_div   <= w_b_mag;
      r_dvd   <= dividend;
      r_zero  <= (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
      r_q_neg <= w_a_neg ^ w_b_neg;
      r_r_neg <= w_a_neg;
`endif
    end else if (r_state == S_CALC) begin
      r_p  <= w_p_nx;
      r_dq <= w_dq_nx;
      if (w_last) begin
        r_quo <= w_q_fin;
        r_rem <= w_r_fin;
        r_dbz <= r_zero;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule
